// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and parameter-derived constants for the configuration chain loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_REL_RST,
    ST_REL_CLK,
    ST_DONE
  } state_e;

  // Host words needed to cover the whole chain.
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits actually sent from the final word; a zero remainder means a full word.
  function automatic int unsigned last_bits(input int unsigned chain_len,
                                            input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

  // Width able to hold 0..chain_len.
  function automatic int unsigned bit_cnt_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Width able to hold 0..word_w.
  function automatic int unsigned word_bit_cnt_w(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

  // Width able to hold 0..n_words.
  function automatic int unsigned word_cnt_w(input int unsigned n_words);
    return $clog2(n_words + 1);
  endfunction

  // Phase counter width, never narrower than one bit.
  function automatic int unsigned phase_cnt_w(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host-to-loader configuration word stream (valid/ready).
interface cfg_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/cfg_chain_loader_clkgen.sv
// Shift clock phase timer: each shift_clk phase lasts DIV system-clock cycles.
module cfg_shift_clkgen
  import cfg_loader_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,          // FSM is in a shift phase
  input  logic hi_d_i,        // FSM next state is the high phase
  output logic phase_done_o,  // current phase ends this cycle
  output logic shift_clk_o
);

  localparam int unsigned PH_W = phase_cnt_w(DIV);

  logic [PH_W-1:0] cnt_q, cnt_d;
  logic            sclk_q;

  assign phase_done_o = en_i && (cnt_q == PH_W'(DIV - 1));
  assign shift_clk_o  = sclk_q;

  // Count cycles within a phase; restart at every phase boundary or when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || phase_done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PH_W'(1);
    end
  end

  // Phase counter and registered shift clock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= hi_d_i;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: serialises host words onto the fabric shift chain,
// holding the fabric in reset until loading completes, then releasing reset
// before enabling the fabric clock.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned DIV       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  cfg_chain_loader_if.slave cfg,
  output logic              shift_clk,
  output logic              shift_o,
  output logic              fabric_rst,
  output logic              fabric_clk_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int unsigned LAST_BITS = last_bits(CHAIN_LEN, WORD_W);
  localparam int unsigned BIT_W     = bit_cnt_w(CHAIN_LEN);
  localparam int unsigned WB_W      = word_bit_cnt_w(WORD_W);
  localparam int unsigned WC_W      = word_cnt_w(NUM_WORDS);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d, sreg_shift;
  logic              shift_o_q, shift_o_d;
  logic [BIT_W-1:0]  bit_q, bit_d, bit_inc;
  logic [WB_W-1:0]   wbit_q, wbit_d, wbit_inc, word_len;
  logic [WC_W-1:0]   word_q, word_d;
  logic              rel_q, rel_d;
  logic              ready_q, busy_q, done_q, frst_q, fen_q;
  logic              hs, phase_done, sh_en, sh_hi_d;

  assign hs         = cfg.cfg_valid && ready_q;
  assign sreg_shift = sreg_q >> 1;
  assign bit_inc    = bit_q + BIT_W'(1);
  assign wbit_inc   = wbit_q + WB_W'(1);
  assign sh_en      = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
  assign sh_hi_d    = (state_d == ST_SHIFT_HI);

  cfg_shift_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (sh_en),
    .hi_d_i       (sh_hi_d),
    .phase_done_o (phase_done),
    .shift_clk_o  (shift_clk)
  );

  // Next-state and datapath updates for the load/shift/release sequence.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    shift_o_d = shift_o_q;
    bit_d     = bit_q;
    wbit_d    = wbit_q;
    word_d    = word_q;
    rel_d     = rel_q;
    // The final word is truncated so the chain receives exactly CHAIN_LEN bits.
    word_len  = (word_q == WC_W'(NUM_WORDS)) ? WB_W'(LAST_BITS) : WB_W'(WORD_W);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          bit_d   = '0;
          wbit_d  = '0;
          word_d  = '0;
          rel_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          sreg_d    = cfg.cfg_data;
          shift_o_d = cfg.cfg_data[0];
          word_d    = word_q + WC_W'(1);
          wbit_d    = '0;
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_done) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_done) begin
          bit_d = bit_inc;
          if (bit_inc == BIT_W'(CHAIN_LEN)) begin
            state_d = ST_REL_RST;
          end else if (wbit_inc == word_len) begin
            wbit_d  = '0;
            state_d = ST_LOAD;
          end else begin
            // Next bit is presented together with the falling shift_clk edge.
            wbit_d    = wbit_inc;
            sreg_d    = sreg_shift;
            shift_o_d = sreg_shift[0];
            state_d   = ST_SHIFT_LO;
          end
        end
      end
      ST_REL_RST: begin
        if (rel_q) begin
          state_d = ST_REL_CLK;
        end else begin
          rel_d = 1'b1;
        end
      end
      ST_REL_CLK: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      shift_o_q <= 1'b0;
      bit_q     <= '0;
      wbit_q    <= '0;
      word_q    <= '0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      shift_o_q <= shift_o_d;
      bit_q     <= bit_d;
      wbit_q    <= wbit_d;
      word_q    <= word_d;
      rel_q     <= rel_d;
    end
  end

  // Control outputs are decoded from the next state so they are flop outputs
  // yet change in the same cycle the state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      frst_q  <= 1'b1;
      fen_q   <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_LOAD);
      busy_q  <= !(state_d inside {ST_IDLE, ST_DONE});
      done_q  <= (state_d == ST_DONE);
      frst_q  <= !(state_d inside {ST_REL_RST, ST_REL_CLK, ST_DONE});
      fen_q   <= (state_d inside {ST_REL_CLK, ST_DONE});
    end
  end

  assign cfg.cfg_ready  = ready_q;
  assign shift_o        = shift_o_q;
  assign fabric_rst     = frst_q;
  assign fabric_clk_en  = fen_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a DIV=1 and a DIV=3 instance, each with
// a behavioural 10-cell chain model fed from shift_clk/shift_o.
module tb_cfg_chain_loader;

  localparam int unsigned CL = 10;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_v [2];
  logic          valid_v [2];
  logic [WW-1:0] data_v  [2];
  logic [1:0]    rdy, sclk, so, frst, fen, bsy, dn;
  logic [WW-1:0] words [3] = '{4'hA, 4'h5, 4'h3};

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  cfg_chain_loader_if #(.WORD_W(WW)) if1 ();
  cfg_chain_loader_if #(.WORD_W(WW)) if3 ();

  assign if1.cfg_data  = data_v[0];
  assign if1.cfg_valid = valid_v[0];
  assign if3.cfg_data  = data_v[1];
  assign if3.cfg_valid = valid_v[1];
  assign rdy[0] = if1.cfg_ready;
  assign rdy[1] = if3.cfg_ready;

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cfg(if1),
    .shift_clk(sclk[0]), .shift_o(so[0]), .fabric_rst(frst[0]),
    .fabric_clk_en(fen[0]), .busy(bsy[0]), .done(dn[0])
  );

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cfg(if3),
    .shift_clk(sclk[1]), .shift_o(so[1]), .fabric_rst(frst[1]),
    .fabric_clk_en(fen[1]), .busy(bsy[1]), .done(dn[1])
  );

  // Per-instance chain model, handshake/edge counters and protocol monitors.
  for (genvar k = 0; k < 2; k++) begin : mon
    localparam int unsigned DIVK = (k == 0) ? 1 : 3;
    logic [CL-1:0] chain = '0;
    int unsigned edges = 0, hs = 0;
    int unsigned setup_viol = 0, phase_viol = 0, rel_viol = 0;
    int unsigned hi_run = 0, lo_run = 0, rst_low = 0;
    logic psclk = 1'b0, pso = 1'b0, pfen = 1'b0;

    // First bit shifted ends in the far cell (index CL-1).
    always @(posedge sclk[k]) begin
      chain <= {chain[CL-2:0], so[k]};
      edges <= edges + 1;
    end

    always @(posedge clk) begin
      if (rdy[k] === 1'b1 && valid_v[k] === 1'b1) hs <= hs + 1;
    end

    always begin
      @(posedge clk);
      #1;
      if (so[k] !== pso && sclk[k] === 1'b1) setup_viol++;
      if (sclk[k] === 1'b1) begin
        if (!psclk && lo_run < DIVK) phase_viol++;
        hi_run++;
        lo_run = 0;
      end else begin
        if (psclk && hi_run != DIVK) phase_viol++;
        lo_run++;
        hi_run = 0;
      end
      if (frst[k] !== 1'b0) rst_low = 0;
      else rst_low++;
      if (fen[k] === 1'b1 && !pfen && rst_low < 3) rel_viol++;
      if (fen[k] === 1'b1 && frst[k] === 1'b1) rel_viol++;
      psclk = sclk[k];
      pso   = so[k];
      pfen  = fen[k];
    end
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int unsigned obs, input int unsigned exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait at negedges for cfg_ready (is_done=0) or done (is_done=1), bounded.
  task automatic wait_for(input int sel, input bit is_done, input string tag,
                          input int unsigned budget);
    int unsigned n = 0;
    while (((is_done ? dn[sel] : rdy[sel]) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_b(tag, is_done ? dn[sel] : rdy[sel], 1'b1);
  endtask

  // Host: present nwords words; optional stall before word 2 and start pulses.
  task automatic send_words(input int sel, input int nwords, input bit stall, input bit inj);
    for (int w = 0; w < nwords; w++) begin
      if (stall && w == 1) begin
        valid_v[sel] = 1'b0;
        wait_for(sel, 1'b0, "stall_ready", 200);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk_b("stall_shift_clk", sclk[sel], 1'b0);
          chk_b("stall_shift_o", so[sel], 1'b1);  // last bit of 0xA
          chk_b("stall_ready_held", rdy[sel], 1'b1);
        end
      end
      data_v[sel]  = words[w];
      valid_v[sel] = 1'b1;
      wait_for(sel, 1'b0, "ready", 200);
      if (inj && w == 1) start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      if (inj && w == 0) begin
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
      end
    end
    valid_v[sel] = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  initial begin
    int unsigned be, bh, t0;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      valid_v[k] = 1'b0;
      data_v[k]  = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk_b("rst_shift_clk", sclk[0], 1'b0);
    chk_b("rst_shift_o", so[0], 1'b0);
    chk_b("rst_cfg_ready", rdy[0], 1'b0);
    chk_b("rst_fabric_rst", frst[0], 1'b1);
    chk_b("rst_fabric_clk_en", fen[0], 1'b0);
    chk_b("rst_busy", bsy[0], 1'b0);
    chk_b("rst_done", dn[0], 1'b0);
    chk_b("rst_fabric_rst_div3", frst[1], 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal load, valid held high.
    be = mon[0].edges; bh = mon[0].hs; t0 = cyc;
    pulse_start(0);
    chk_b("a_busy", bsy[0], 1'b1);
    chk_b("a_ready", rdy[0], 1'b1);
    chk_b("a_fabric_rst", frst[0], 1'b1);
    chk_b("a_fabric_clk_en", fen[0], 1'b0);
    send_words(0, 3, 1'b0, 1'b0);
    wait_for(0, 1'b1, "a_done", 100);
    chk_n("a_latency", cyc - t0 - 1, 3 + CL * 2 + 2 + 1);
    chk_n("a_edges", mon[0].edges - be, CL);
    chk_n("a_handshakes", mon[0].hs - bh, 3);
    chk_n("a_chain", 32'(mon[0].chain), 32'h16B);
    chk_b("a_busy_end", bsy[0], 1'b0);
    chk_b("a_fabric_rst_end", frst[0], 1'b0);
    chk_b("a_fabric_clk_en_end", fen[0], 1'b1);

    // cfg_valid in DONE is not consumed.
    data_v[0] = 4'hF; valid_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk_b("done_ready_low", rdy[0], 1'b0);
    chk_n("done_no_handshake", mon[0].hs - bh, 3);
    valid_v[0] = 1'b0;

    // Restart from DONE with a host stall before word 2.
    be = mon[0].edges; bh = mon[0].hs; t0 = cyc;
    pulse_start(0);
    chk_b("b_fabric_clk_en", fen[0], 1'b0);
    chk_b("b_fabric_rst", frst[0], 1'b1);
    chk_b("b_done", dn[0], 1'b0);
    send_words(0, 3, 1'b1, 1'b0);
    wait_for(0, 1'b1, "b_done", 100);
    chk_n("b_latency", cyc - t0 - 1, 3 + CL * 2 + 2 + 1 + 5);
    chk_n("b_edges", mon[0].edges - be, CL);
    chk_n("b_handshakes", mon[0].hs - bh, 3);
    chk_n("b_chain", 32'(mon[0].chain), 32'h16B);

    // start pulses during SHIFT and LOAD are ignored.
    be = mon[0].edges; bh = mon[0].hs; t0 = cyc;
    pulse_start(0);
    send_words(0, 3, 1'b0, 1'b1);
    wait_for(0, 1'b1, "c_done", 100);
    chk_n("c_latency", cyc - t0 - 1, 3 + CL * 2 + 2 + 1);
    chk_n("c_edges", mon[0].edges - be, CL);
    chk_n("c_handshakes", mon[0].hs - bh, 3);
    chk_n("c_chain", 32'(mon[0].chain), 32'h16B);

    // Asynchronous reset in the middle of word 2.
    bh = mon[0].hs;
    pulse_start(0);
    send_words(0, 2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_b("d_fabric_rst", frst[0], 1'b1);
    chk_b("d_fabric_clk_en", fen[0], 1'b0);
    chk_b("d_shift_clk", sclk[0], 1'b0);
    chk_b("d_busy", bsy[0], 1'b0);
    chk_b("d_ready", rdy[0], 1'b0);
    chk_n("d_partial_handshakes", mon[0].hs - bh, 2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    be = mon[0].edges; bh = mon[0].hs;
    pulse_start(0);
    send_words(0, 3, 1'b0, 1'b0);
    wait_for(0, 1'b1, "d_done", 100);
    chk_n("d_edges", mon[0].edges - be, CL);
    chk_n("d_handshakes", mon[0].hs - bh, 3);
    chk_n("d_chain", 32'(mon[0].chain), 32'h16B);

    // DIV=3 instance.
    be = mon[1].edges; bh = mon[1].hs; t0 = cyc;
    pulse_start(1);
    chk_b("e_busy", bsy[1], 1'b1);
    send_words(1, 3, 1'b0, 1'b0);
    wait_for(1, 1'b1, "e_done", 300);
    chk_n("e_latency", cyc - t0 - 1, 3 + CL * 6 + 2 + 1);
    chk_n("e_edges", mon[1].edges - be, CL);
    chk_n("e_handshakes", mon[1].hs - bh, 3);
    chk_n("e_chain", 32'(mon[1].chain), 32'h16B);
    chk_n("e_phase_width", mon[1].phase_viol, 0);

    @(negedge clk);
    chk_n("setup_hold_div1", mon[0].setup_viol, 0);
    chk_n("setup_hold_div3", mon[1].setup_viol, 0);
    chk_n("release_order_div1", mon[0].rel_viol, 0);
    chk_n("release_order_div3", mon[1].rel_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

endmodule
